// File: rtl/cpu_axi3_shim_if.sv
// Bus bundles for the CPU AXI3 -> SoC AXI4 shim.
//
// cpu_axi3_shim_if       : AXI3-style port of the CPU core (4-bit len, 2-bit
//                          lock, W carries wid).
// cpu_axi3_shim_axi4_if  : AXI4 port towards the SoC AXI_BUS fabric (8-bit
//                          len, 1-bit lock, no wid).
//
// Both bundles offer a 'master' modport (drives AW/W/AR, consumes B/R) and a
// 'slave' modport (the mirror image).

interface cpu_axi3_shim_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [3:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic [1:0]              awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;

  logic [ID_WIDTH-1:0]     wid;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [3:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic [1:0]              arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

interface cpu_axi3_shim_axi4_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/cpu_axi3_shim.sv
// cpu_axi3_shim: sits between a CPU core's AXI3-style master port and the
// AXI4 SoC fabric. Widens len to 8 bits, narrows lock to 1 bit (only
// exclusive survives), caps in-flight reads and writes at MAX_OUTSTANDING,
// and offers a drain/quiesce handshake for isolating the core.
//
// Optional feature macro: CPU_AXI3_SHIM_WBUF_EN
//   defined   -> W beats pass through a W_DEPTH-entry FIFO (one cycle latency)
//   undefined -> W is a combinational pass-through
//
// Ports:
//   aclk            clock, rising edge
//   aresetn         synchronous, active-low reset
//   s_axi           AXI3 port from the core (slave modport)
//   m_axi           AXI4 port to the fabric (master modport)
//   drain_req       level request to quiesce
//   drain_ack       high while quiesced
//   rd_outstanding  reads in flight
//   wr_outstanding  writes in flight

module cpu_axi3_shim #(
  parameter int ID_WIDTH        = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 8,
  parameter int W_DEPTH         = 4
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  cpu_axi3_shim_if.slave               s_axi,
  cpu_axi3_shim_axi4_if.master         m_axi,
  input  logic                         drain_req,
  output logic                         drain_ack,
  output logic [7:0]                   rd_outstanding,
  output logic [7:0]                   wr_outstanding
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {ST_RUN, ST_DRAINING, ST_DRAINED} state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic       w_run;

  logic [7:0] r_rd_cnt;
  logic [7:0] r_wr_cnt;
  logic       r_ar_hold;
  logic       r_aw_hold;

  logic       w_ar_block;
  logic       w_aw_block;
  logic       w_ar_hs;
  logic       w_aw_hs;
  logic       w_r_done;
  logic       w_b_done;
  logic       w_wbuf_empty;
  logic       w_idle;
  logic       w_unused;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge aclk) begin
    if (!aresetn) r_state <= ST_RUN;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:      if (drain_req) w_state_next = ST_DRAINING;
      ST_DRAINING: begin
        if (!drain_req)  w_state_next = ST_RUN;
        else if (w_idle) w_state_next = ST_DRAINED;
      end
      ST_DRAINED:  if (!drain_req) w_state_next = ST_RUN;
      default:     w_state_next = ST_RUN;
    endcase
  end

  always_comb begin
    w_run     = (r_state == ST_RUN);
    drain_ack = (r_state == ST_DRAINED);
  end

  // Quiesced means nothing in flight, nothing being offered and no buffered W.
  assign w_idle = (r_rd_cnt == 8'd0) && (r_wr_cnt == 8'd0) &&
                  !r_ar_hold && !r_aw_hold && w_wbuf_empty;

  // ------------------------------------------------------ address gating
  // A request already presented downstream must stay up until accepted, so
  // the hold flag overrides both the outstanding cap and the drain state.
  assign w_ar_block = !r_ar_hold && ((r_rd_cnt == MAX_CNT) || !w_run);
  assign w_aw_block = !r_aw_hold && ((r_wr_cnt == MAX_CNT) || !w_run);

  assign m_axi.arvalid = aresetn && s_axi.arvalid && !w_ar_block;
  assign s_axi.arready = aresetn && m_axi.arready && !w_ar_block;
  assign m_axi.awvalid = aresetn && s_axi.awvalid && !w_aw_block;
  assign s_axi.awready = aresetn && m_axi.awready && !w_aw_block;

  assign m_axi.arid    = s_axi.arid;
  assign m_axi.araddr  = s_axi.araddr;
  assign m_axi.arlen   = {4'b0000, s_axi.arlen};
  assign m_axi.arsize  = s_axi.arsize;
  assign m_axi.arburst = s_axi.arburst;
  assign m_axi.arlock  = (s_axi.arlock == 2'b01);   // locked (2'b10) becomes normal
  assign m_axi.arcache = s_axi.arcache;
  assign m_axi.arprot  = s_axi.arprot;

  assign m_axi.awid    = s_axi.awid;
  assign m_axi.awaddr  = s_axi.awaddr;
  assign m_axi.awlen   = {4'b0000, s_axi.awlen};
  assign m_axi.awsize  = s_axi.awsize;
  assign m_axi.awburst = s_axi.awburst;
  assign m_axi.awlock  = (s_axi.awlock == 2'b01);
  assign m_axi.awcache = s_axi.awcache;
  assign m_axi.awprot  = s_axi.awprot;

  // ----------------------------------------------------- response paths
  assign s_axi.rid    = m_axi.rid;
  assign s_axi.rdata  = m_axi.rdata;
  assign s_axi.rresp  = m_axi.rresp;
  assign s_axi.rlast  = m_axi.rlast;
  assign s_axi.rvalid = aresetn && m_axi.rvalid;
  assign m_axi.rready = aresetn && s_axi.rready;

  assign s_axi.bid    = m_axi.bid;
  assign s_axi.bresp  = m_axi.bresp;
  assign s_axi.bvalid = aresetn && m_axi.bvalid;
  assign m_axi.bready = aresetn && s_axi.bready;

  assign w_ar_hs  = m_axi.arvalid && m_axi.arready;
  assign w_aw_hs  = m_axi.awvalid && m_axi.awready;
  assign w_r_done = s_axi.rvalid && s_axi.rready && s_axi.rlast;
  assign w_b_done = s_axi.bvalid && s_axi.bready;

  // --------------------------------------------- outstanding counters
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_rd_cnt <= 8'd0;
      r_wr_cnt <= 8'd0;
    end else begin
      case ({w_ar_hs, w_r_done})
        2'b10:   if (r_rd_cnt != 8'hFF) r_rd_cnt <= r_rd_cnt + 8'd1;
        2'b01:   if (r_rd_cnt != 8'h00) r_rd_cnt <= r_rd_cnt - 8'd1;
        default: r_rd_cnt <= r_rd_cnt;
      endcase
      case ({w_aw_hs, w_b_done})
        2'b10:   if (r_wr_cnt != 8'hFF) r_wr_cnt <= r_wr_cnt + 8'd1;
        2'b01:   if (r_wr_cnt != 8'h00) r_wr_cnt <= r_wr_cnt - 8'd1;
        default: r_wr_cnt <= r_wr_cnt;
      endcase
    end
  end

  assign rd_outstanding = r_rd_cnt;
  assign wr_outstanding = r_wr_cnt;

  // ---------------------------------------------------- hold flags
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_ar_hold <= 1'b0;
      r_aw_hold <= 1'b0;
    end else begin
      if (w_ar_hs)            r_ar_hold <= 1'b0;
      else if (m_axi.arvalid) r_ar_hold <= 1'b1;
      if (w_aw_hs)            r_aw_hold <= 1'b0;
      else if (m_axi.awvalid) r_aw_hold <= 1'b1;
    end
  end

  // ------------------------------------------------------------ W path
`ifdef CPU_AXI3_SHIM_WBUF_EN
  localparam int PTR_W  = $clog2(W_DEPTH);
  localparam int WORD_W = DATA_WIDTH + DATA_WIDTH/8 + 1;

  logic [WORD_W-1:0] r_wmem [W_DEPTH];
  logic [PTR_W:0]    r_wr_ptr;
  logic [PTR_W:0]    r_rd_ptr;
  logic [WORD_W-1:0] w_rd_word;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

  // No bypass when full: a pop in the same cycle does not open a slot.
  assign s_axi.wready = aresetn && !w_full;
  assign m_axi.wvalid = aresetn && !w_empty;
  assign w_push       = s_axi.wvalid && s_axi.wready;
  assign w_pop        = m_axi.wvalid && m_axi.wready;

  always_ff @(posedge aclk) begin
    if (w_push) r_wmem[r_wr_ptr[PTR_W-1:0]] <= {s_axi.wdata, s_axi.wstrb, s_axi.wlast};
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Head entry comes straight from storage: data is never combinational
  // from the core side.
  assign w_rd_word    = r_wmem[r_rd_ptr[PTR_W-1:0]];
  assign m_axi.wdata  = w_rd_word[WORD_W-1 -: DATA_WIDTH];
  assign m_axi.wstrb  = w_rd_word[DATA_WIDTH/8:1];
  assign m_axi.wlast  = w_rd_word[0];
  assign w_wbuf_empty = w_empty;

  assign w_unused = ^{s_axi.wid, ID_WIDTH, ADDR_WIDTH};
`else
  assign m_axi.wdata  = s_axi.wdata;
  assign m_axi.wstrb  = s_axi.wstrb;
  assign m_axi.wlast  = s_axi.wlast;
  assign m_axi.wvalid = aresetn && s_axi.wvalid;
  assign s_axi.wready = aresetn && m_axi.wready;
  assign w_wbuf_empty = 1'b1;

  assign w_unused = ^{s_axi.wid, ID_WIDTH, ADDR_WIDTH, DATA_WIDTH, W_DEPTH};
`endif

endmodule
